pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the RV32I 5-stage core. Generates the register-enable, flush and bubble controls for the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers. It resolves three events: load-use hazards, taken branches/jumps resolved in EXE, and data-memory wait states. It sits beside the decode stage and drives the pipeline registers directly. A bubble at ID/EXE means the pipeline register loads zero into its CRT_WB/CRT_MEM/CRT_EXE control fields.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I core's pipeline control logic.
package riscv_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO             = 5'd0;
  localparam int         FLUSH_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use detector: a load in EXE whose destination is read by the instruction in ID.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  output logic       load_use_o
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign load_use_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != REG_ZERO) &&
                      id_valid_i && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: PC/IF-ID/ID-EXE/EXE-MEM enables, flush and bubble.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // The branch cycle itself is the first kill, so FLUSH covers the remaining ones.
  localparam logic [1:0] FLUSH_INIT = 2'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  hz_state_t  state_q, state_d;
  hz_state_t  ret_q, ret_d;
  logic [1:0] flush_ctr_q, flush_ctr_d;
  logic       load_use;

  load_use_detect u_load_use_detect (
    .ex_valid_i    (ex_valid),
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .load_use_o    (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      flush_ctr_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_ctr_q <= flush_ctr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    flush_ctr_d  = flush_ctr_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b1;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (mem_busy) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            state_d = MEM_WAIT;
            ret_d   = RUN;
          end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = FLUSH;
              flush_ctr_d = FLUSH_INIT;
            end
          end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        // EXE holds a bubble here, so branch and load-use inputs are don't-care.
        FLUSH: begin
          if (mem_busy) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            state_d = MEM_WAIT;
            ret_d   = FLUSH;
          end else begin
            if_id_flush = 1'b1;
            if (flush_ctr_q == 2'd0) state_d = RUN;
            else flush_ctr_d = flush_ctr_q - 2'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_busy) {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          else state_d = ret_q;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign hz_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_inc, branch_acc;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign stall_inc  = (state_q == RUN && !mem_busy && !ex_branch_taken && load_use) ||
                      !(pc_en || if_id_en || id_ex_en || ex_mem_en);
  assign branch_acc = (state_q == RUN) && !mem_busy && ex_branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc)  stall_q <= stall_q + CNT_W'(1);
      if (branch_acc) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controllers (FLUSH_CYCLES 2 and 3) share stimulus and are
// compared every cycle against a kill-count/wait-flag reference model.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst, id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read;
  logic ex_branch_taken, mem_busy;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [1:0] pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en;
  logic [1:0] hz [2];
  logic [31:0] sc_o [2];
  logic [31:0] fe_o [2];

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          kills [2];
  bit          waiting [2];
  logic [31:0] sc_m [2];
  logic [31:0] fe_m [2];
  int          fcv [2] = '{2, 3};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_en(pc_en[0]), .if_id_en(if_id_en[0]),
    .if_id_flush(if_id_flush[0]), .id_ex_en(id_ex_en[0]), .id_ex_bubble(id_ex_bubble[0]),
    .ex_mem_en(ex_mem_en[0]), .hz_state(hz[0]), .stall_cycles(sc_o[0]),
    .flush_events(fe_o[0]));

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_en(pc_en[1]), .if_id_en(if_id_en[1]),
    .if_id_flush(if_id_flush[1]), .id_ex_en(id_ex_en[1]), .id_ex_bubble(id_ex_bubble[1]),
    .ex_mem_en(ex_mem_en[1]), .hz_state(hz[1]), .stall_cycles(sc_o[1]),
    .flush_events(fe_o[1]));

  // Reference: kills = fetch kills still owed after a branch, waiting = memory freeze.
  task automatic model(input int d, output exp_t e);
    bit pc, ifid, fl, idex, bub, exm, allz, lus, bra, lu;
    lu = ex_valid && ex_mem_read && ex_rd != 5'd0 && id_valid &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    e.st = waiting[d] ? 2'd2 : (kills[d] > 0 ? 2'd1 : 2'd0);
    e.sc = PERF ? sc_m[d] : 32'd0;
    e.fe = PERF ? fe_m[d] : 32'd0;
    {pc, ifid, fl, idex, bub, exm} = 6'b110101;
    {allz, lus, bra} = 3'b000;
    if (rst) begin
      kills[d] = 0; waiting[d] = 0; sc_m[d] = 0; fe_m[d] = 0;
    end else begin
      if (waiting[d]) begin
        if (mem_busy) allz = 1; else waiting[d] = 0;
      end else if (mem_busy) begin
        allz = 1; waiting[d] = 1;
      end else if (kills[d] > 0) begin
        fl = 1; kills[d]--;
      end else if (ex_branch_taken) begin
        fl = 1; bub = 1; kills[d] = fcv[d] - 1; bra = 1;
      end else if (lu) begin
        pc = 0; ifid = 0; bub = 1; lus = 1;
      end
      if (allz) {pc, ifid, idex, exm} = 4'b0000;
      if (allz || lus) sc_m[d]++;
      if (bra) fe_m[d]++;
    end
    e.ctl = {pc, ifid, fl, idex, bub, exm};
  endtask

  task automatic step();
    exp_t e;
    model(0, e); q0.push_back(e);
    model(1, e); q1.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic clr();
    {id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read} = 5'b0;
    {ex_branch_taken, mem_busy} = 2'b0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
  endtask

  task automatic set_lu();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5; id_valid = 1; id_uses_rs2 = 1; id_rs2 = 5;
  endtask

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d actual %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic compare(input int d, input exp_t e);
    chk("controls", d, {26'd0, pc_en[d], if_id_en[d], if_id_flush[d], id_ex_en[d],
                        id_ex_bubble[d], ex_mem_en[d]}, {26'd0, e.ctl});
    chk("hz_state", d, {30'd0, hz[d]}, {30'd0, e.st});
    chk("stall_cycles", d, sc_o[d], e.sc);
    chk("flush_events", d, fe_o[d], e.fe);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (q0.size() > 0) begin e = q0.pop_front(); compare(0, e); end
      if (q1.size() > 0) begin e = q1.pop_front(); compare(1, e); end
    end
  end

  initial begin : stimulus
    for (int d = 0; d < 2; d++) begin
      kills[d] = 0; waiting[d] = 0; sc_m[d] = 0; fe_m[d] = 0;
    end
    clr(); rst = 1;
    @(posedge clk); #1;
    step(); rst = 0;
    // load-use, then release
    set_lu(); step(); ex_valid = 0; step();
    // x0 destination, unused source
    clr(); ex_valid = 1; ex_mem_read = 1; id_valid = 1; id_uses_rs1 = 1; step();
    ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 0; step();
    // taken branch
    clr(); ex_branch_taken = 1; step(); ex_branch_taken = 0;
    repeat (3) step();
    // priority: busy over branch over load-use
    set_lu(); ex_branch_taken = 1; mem_busy = 1;
    repeat (3) step();
    mem_busy = 0; step(); step();
    clr(); repeat (3) step();
    // busy in second flush cycle
    ex_branch_taken = 1; step(); ex_branch_taken = 0; step();
    mem_busy = 1; repeat (2) step(); mem_busy = 0;
    repeat (3) step();
    // reset during memory wait
    mem_busy = 1; step(); rst = 1; step(); rst = 0; mem_busy = 0; step(); step();
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      rst             = ($urandom_range(63) == 0);
      id_valid        = ($urandom_range(3) != 0);
      id_rs1          = 5'($urandom_range(3));
      id_rs2          = 5'($urandom_range(3));
      id_uses_rs1     = $urandom_range(1);
      id_uses_rs2     = $urandom_range(1);
      ex_valid        = ($urandom_range(3) != 0);
      ex_mem_read     = $urandom_range(1);
      ex_rd           = 5'($urandom_range(3));
      ex_branch_taken = ($urandom_range(5) == 0);
      mem_busy        = ($urandom_range(4) == 0);
      step();
    end
    clr();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d expected 0", q0.size() + q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
